// File: rtl/buyruk_getirici_pkg.sv
// Shared types and constants for the instruction supply block.
// Holds the load FSM states, the default NOP word and byte-index sizing.
package buyruk_getirici_pkg;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    YUKLE = 2'd1,
    HAZIR = 2'd2
  } durum_e;

  // addi x0,x0,0
  localparam logic [31:0] BUYRUK_NOP = 32'h0000_0013;

  // Four bytes per 32-bit word.
  localparam int unsigned BAYT_IDX_W = 2;
  localparam logic [BAYT_IDX_W-1:0] BAYT_SON = '1;

endpackage

// File: rtl/buyruk_bellegi.sv
// Instruction memory: one synchronous write port, asynchronous read.
// Ports: saat_i, yaz_en_i/yaz_adr_i/yaz_veri_i (write), oku_adr_i/oku_veri_o (read).
module buyruk_bellegi #(
  parameter int unsigned DERINLIK = 256,
  parameter int unsigned AW = $clog2(DERINLIK)
) (
  input  logic          saat_i,
  input  logic          yaz_en_i,
  input  logic [AW-1:0] yaz_adr_i,
  input  logic [31:0]   yaz_veri_i,
  input  logic [AW-1:0] oku_adr_i,
  output logic [31:0]   oku_veri_o
);

  // No reset: contents survive a reset and are gated by the word count.
  logic [31:0] mem_q [DERINLIK];

  always_ff @(posedge saat_i) begin
    if (yaz_en_i) begin
      mem_q[yaz_adr_i] <= yaz_veri_i;
    end
  end

  assign oku_veri_o = mem_q[oku_adr_i];

endmodule

// File: rtl/buyruk_getirici.sv
// Program loader and zero-latency instruction fetch for a single-cycle core.
// Ports: byte-stream load (yukle_basla, bayt*, yukle_son), fetch (ps, buyruk,
// hizalama_hatasi, sinir_hatasi), islemci_reset and yuklenen_kelime.
module buyruk_getirici
  import buyruk_getirici_pkg::*;
#(
  parameter int unsigned ADRES_GENISLIGI = 8,
  parameter logic [31:0] NOP_BUYRUK = BUYRUK_NOP
) (
  input  logic                     saat,
  input  logic                     reset,
  input  logic                     yukle_basla,
  input  logic                     bayt_gecerli,
  input  logic [7:0]               bayt,
  input  logic                     yukle_son,
  output logic                     bayt_hazir,
  input  logic [31:0]              ps,
  output logic [31:0]              buyruk,
  output logic                     islemci_reset,
  output logic [ADRES_GENISLIGI:0] yuklenen_kelime,
  output logic                     hizalama_hatasi,
  output logic                     sinir_hatasi
);

  localparam int unsigned AW = ADRES_GENISLIGI;
  localparam int unsigned DERINLIK = 1 << AW;
  localparam logic [AW:0] KAPASITE = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] SON_INDIS = KAPASITE - 1'b1;

  durum_e                durum_q;
  logic [BAYT_IDX_W-1:0] bayt_say_q;
  logic [AW:0]           kelime_say_q;
  logic [AW:0]           kelime_say_d;
  logic [31:0]           toplama_q;
  logic [31:0]           toplama_d;
  logic [AW:0]           yuklenen_q;
  logic                  islemci_reset_q;

  logic                  kabul;
  logic                  yaz;
  logic                  bitir;
  logic [AW-1:0]         oku_adr;
  logic [31:0]           oku_veri;

  assign bayt_hazir = (durum_q == YUKLE);

  // A restart pulse wins over a byte offered in the same cycle.
  assign kabul = bayt_gecerli & bayt_hazir & ~yukle_basla;

  // Upper bytes are still zero from the last clear, so a short final
  // word comes out zero-filled without extra masking.
  assign toplama_d = toplama_q
                   | (32'(bayt) << {bayt_say_q, 3'b000});

  assign yaz = kabul
             & (yukle_son | (bayt_say_q == BAYT_SON));

  assign bitir = yaz
               & (yukle_son | (kelime_say_q == SON_INDIS));

  assign kelime_say_d = (kelime_say_q == KAPASITE)
                      ? kelime_say_q
                      : kelime_say_q + 1'b1;

  always_ff @(posedge saat) begin
    if (reset) begin
      durum_q         <= BOS;
      bayt_say_q      <= '0;
      kelime_say_q    <= '0;
      toplama_q       <= '0;
      yuklenen_q      <= '0;
      islemci_reset_q <= 1'b1;
    end else begin
      unique case (durum_q)
        BOS: begin
          if (yukle_basla) begin
            durum_q      <= YUKLE;
            bayt_say_q   <= '0;
            kelime_say_q <= '0;
            toplama_q    <= '0;
            yuklenen_q   <= '0;
          end
        end
        YUKLE: begin
          if (yukle_basla) begin
            bayt_say_q   <= '0;
            kelime_say_q <= '0;
            toplama_q    <= '0;
          end else if (yaz) begin
            bayt_say_q   <= '0;
            toplama_q    <= '0;
            kelime_say_q <= kelime_say_d;
            if (bitir) begin
              durum_q         <= HAZIR;
              yuklenen_q      <= kelime_say_d;
              islemci_reset_q <= 1'b0;
            end
          end else if (kabul) begin
            bayt_say_q <= bayt_say_q + 1'b1;
            toplama_q  <= toplama_d;
          end
        end
        HAZIR: begin
          if (yukle_basla) begin
            durum_q         <= YUKLE;
            bayt_say_q      <= '0;
            kelime_say_q    <= '0;
            toplama_q       <= '0;
            yuklenen_q      <= '0;
            islemci_reset_q <= 1'b1;
          end
        end
        default: begin
          durum_q         <= BOS;
          islemci_reset_q <= 1'b1;
        end
      endcase
    end
  end

  buyruk_bellegi #(
    .DERINLIK (DERINLIK),
    .AW       (AW)
  ) u_bellek (
    .saat_i     (saat),
    .yaz_en_i   (yaz),
    .yaz_adr_i  (kelime_say_q[AW-1:0]),
    .yaz_veri_i (toplama_d),
    .oku_adr_i  (oku_adr),
    .oku_veri_o (oku_veri)
  );

  assign oku_adr = ps[AW+1:2];

  assign hizalama_hatasi = |ps[1:0];

  // Count is zero outside HAZIR, so every fetch is out of bounds there.
  assign sinir_hatasi = ps[31:2] >= 30'(yuklenen_q);

  assign buyruk = (hizalama_hatasi | sinir_hatasi)
                ? NOP_BUYRUK
                : oku_veri;

  assign yuklenen_kelime = yuklenen_q;
  assign islemci_reset   = islemci_reset_q;

endmodule
